// File: rtl/cmpndr_word_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmpndr_word_packer: pairs 16-bit companded samples into framed 32-bit words
// behind a first-word-fall-through FIFO.  Rev 1.0
// ---------------------------------------------------------------------------
module cmpndr_word_packer #(
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int FRAME_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     s_pack_d,
  input  logic                      s_pack_dv,
  input  logic                      s_pack_flush,
  output logic [2*DATA_WIDTH-1:0]   m_pack_d,
  output logic                      m_pack_dv,
  input  logic                      m_pack_dr,
  output logic                      m_pack_last,
  output logic                      m_pack_ovf,
  input  logic                      ovf_clr
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int WW = 2 * DATA_WIDTH;
  localparam int EW = WW + 1;
  localparam logic [CW-1:0] C_LAST_CNT = CW'(FRAME_WORDS - 1);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] half_q, half_d;
  logic [CW-1:0]         frame_cnt_q, frame_cnt_d;
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [EW-1:0]         mem_d [FIFO_DEPTH];
  logic [EW-1:0]         head_q, head_d;
  logic                  ovf_q, ovf_d;

  logic                  push_req;
  logic                  push_ok;
  logic                  push_last;
  logic [WW-1:0]         push_word;
  logic                  pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  drop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty && m_pack_dr;

  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    push_req    = 1'b0;
    push_word   = '0;
    // Any flush-related push closes the frame, as does the frame's final slot.
    push_last   = s_pack_flush || (frame_cnt_q == C_LAST_CNT);

    case (state_q)
      ST_EMPTY: begin
        if (s_pack_dv) begin
          if (s_pack_flush) begin
            push_req  = 1'b1;
            push_word = {{DATA_WIDTH{1'b0}}, s_pack_d};
          end else begin
            half_d  = s_pack_d;
            state_d = ST_HALF;
          end
        end
      end
      ST_HALF: begin
        if (s_pack_dv) begin
          push_req  = 1'b1;
          push_word = {s_pack_d, half_q};
          state_d   = ST_EMPTY;
        end else if (s_pack_flush) begin
          push_req  = 1'b1;
          push_word = {{DATA_WIDTH{1'b0}}, half_q};
          state_d   = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    push_ok = push_req && (!fifo_full || pop);
    drop    = push_req && fifo_full && !pop;

    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = {push_last, push_word};
    end

    wr_ptr_d = wr_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Head register tracks the next entry; it freezes once the FIFO drains.
    head_d = head_q;
    if (wr_ptr_d != rd_ptr_d) begin
      head_d = mem_d[rd_ptr_d[AW-1:0]];
    end

    frame_cnt_d = frame_cnt_q;
    if (push_ok) begin
      frame_cnt_d = push_last ? '0 : frame_cnt_q + 1'b1;
    end

    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      half_q      <= '0;
      frame_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      head_q      <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      frame_cnt_q <= frame_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      head_q      <= head_d;
      ovf_q       <= ovf_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign m_pack_d    = head_q[WW-1:0];
  assign m_pack_last = head_q[WW];
  assign m_pack_dv   = !fifo_empty;
  assign m_pack_ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cmpndr_word_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cmpndr_word_packer: directed stimulus with a queued scoreboard and an
// independent output monitor.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_cmpndr_word_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] s_pack_d = '0;
  logic        s_pack_dv = 1'b0;
  logic        s_pack_flush = 1'b0;
  logic [31:0] m_pack_d;
  logic        m_pack_dv;
  logic        m_pack_dr = 1'b0;
  logic        m_pack_last;
  logic        m_pack_ovf;
  logic        ovf_clr = 1'b0;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [32:0] sb [$];

  cmpndr_word_packer #(
    .DATA_WIDTH (16),
    .FIFO_DEPTH (8),
    .FRAME_WORDS(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_pack_d    (s_pack_d),
    .s_pack_dv   (s_pack_dv),
    .s_pack_flush(s_pack_flush),
    .m_pack_d    (m_pack_d),
    .m_pack_dv   (m_pack_dv),
    .m_pack_dr   (m_pack_dr),
    .m_pack_last (m_pack_last),
    .m_pack_ovf  (m_pack_ovf),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handshake pops one expected {last, word}.
  always @(negedge clk) begin
    if (rst_n && m_pack_dv && m_pack_dr) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %h expected none", {m_pack_last, m_pack_d});
      end else begin
        chk("word", {m_pack_last, m_pack_d}, sb.pop_front());
      end
    end
  end

  // Inputs change at posedge+1 and are consumed by the following edge.
  task automatic drive(input logic dv, input logic [15:0] d, input logic fl);
    s_pack_dv    = dv;
    s_pack_d     = d;
    s_pack_flush = fl;
    @(posedge clk);
    #1;
    s_pack_dv    = 1'b0;
    s_pack_flush = 1'b0;
  endtask

  task automatic expect_word(input logic last, input logic [31:0] w);
    sb.push_back({last, w});
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((sb.size() != 0 || m_pack_dv) && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_pending", 33'(sb.size()), 33'd0);
  endtask

  task automatic do_reset();
    m_pack_dr = 1'b0;
    rst_n     = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_dv", 33'(m_pack_dv), 33'd0);
    chk("reset_d", {m_pack_last, m_pack_d}, 33'd0);
    chk("reset_ovf", 33'(m_pack_ovf), 33'd0);

    // Back-to-back pairing with first-word latency.
    m_pack_dr = 1'b1;
    expect_word(1'b0, 32'h2222_1111);
    expect_word(1'b0, 32'h4444_3333);
    drive(1'b1, 16'h1111, 1'b0);
    chk("latency_idle", 33'(m_pack_dv), 33'd0);
    drive(1'b1, 16'h2222, 1'b0);
    chk("latency_dv", 33'(m_pack_dv), 33'd1);
    chk("latency_word", 33'(m_pack_d), 33'h2222_1111);
    drive(1'b1, 16'h3333, 1'b0);
    drive(1'b1, 16'h4444, 1'b0);
    wait_drain();

    // Fresh frame: 10 samples, last only on the 4th word.
    do_reset();
    m_pack_dr = 1'b1;
    expect_word(1'b0, 32'h0101_0100);
    expect_word(1'b0, 32'h0103_0102);
    expect_word(1'b0, 32'h0105_0104);
    expect_word(1'b1, 32'h0107_0106);
    expect_word(1'b0, 32'h0109_0108);
    for (int i = 0; i < 10; i++) drive(1'b1, 16'h0100 + 16'(i), 1'b0);

    // Flush padding closes the frame; count restarts at 0.
    expect_word(1'b1, 32'h0000_ABCD);
    drive(1'b1, 16'hABCD, 1'b0);
    drive(1'b0, 16'h0000, 1'b0);
    drive(1'b0, 16'h0000, 1'b0);
    drive(1'b0, 16'h0000, 1'b1);
    expect_word(1'b0, 32'h0C01_0C00);
    expect_word(1'b0, 32'h0C03_0C02);
    expect_word(1'b0, 32'h0C05_0C04);
    expect_word(1'b1, 32'h0C07_0C06);
    for (int i = 0; i < 8; i++) drive(1'b1, 16'h0C00 + 16'(i), 1'b0);

    // Simultaneous dv + flush in EMPTY and in HALF.
    expect_word(1'b1, 32'h0000_5555);
    drive(1'b1, 16'h5555, 1'b1);
    expect_word(1'b1, 32'h7777_6666);
    drive(1'b1, 16'h6666, 1'b0);
    drive(1'b1, 16'h7777, 1'b1);

    // Idle flush after one word must neither emit nor restart the count.
    expect_word(1'b0, 32'h0D01_0D00);
    expect_word(1'b0, 32'h0D03_0D02);
    expect_word(1'b0, 32'h0D05_0D04);
    expect_word(1'b1, 32'h0D07_0D06);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'h0D00 + 16'(i), 1'b0);
      if (i == 1) drive(1'b0, 16'h0000, 1'b1);
    end
    wait_drain();

    // Back-pressure: 9 words offered into 8 slots.
    do_reset();
    m_pack_dr = 1'b0;
    expect_word(1'b0, 32'hB001_B000);
    expect_word(1'b0, 32'hB003_B002);
    expect_word(1'b0, 32'hB005_B004);
    expect_word(1'b1, 32'hB007_B006);
    expect_word(1'b0, 32'hB009_B008);
    expect_word(1'b0, 32'hB00B_B00A);
    expect_word(1'b0, 32'hB00D_B00C);
    expect_word(1'b1, 32'hB00F_B00E);
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 16'hB000 + 16'(i), 1'b0);
      if (i == 15) chk("ovf_before_drop", 33'(m_pack_ovf), 33'd0);
    end
    drive(1'b1, 16'hB011, 1'b0);
    chk("ovf_set", 33'(m_pack_ovf), 33'd1);
    chk("full_dv", 33'(m_pack_dv), 33'd1);
    chk("stall_head", {m_pack_last, m_pack_d}, {1'b0, 32'hB001_B000});
    repeat (4) drive(1'b0, 16'h0000, 1'b0);
    chk("stall_hold", {m_pack_last, m_pack_d}, {1'b0, 32'hB001_B000});

    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    chk("ovf_clr", 33'(m_pack_ovf), 33'd0);

    // Full FIFO: pop and push on the same edge must not drop.
    expect_word(1'b0, 32'h9002_9001);
    drive(1'b1, 16'h9001, 1'b0);
    m_pack_dr = 1'b1;
    drive(1'b1, 16'h9002, 1'b0);
    chk("no_drop_ovf", 33'(m_pack_ovf), 33'd0);
    wait_drain();
    chk("ovf_after_drain", 33'(m_pack_ovf), 33'd0);

    // Reset mid-operation discards queued word and pending half.
    m_pack_dr = 1'b0;
    drive(1'b1, 16'hE000, 1'b0);
    drive(1'b1, 16'hE001, 1'b0);
    drive(1'b1, 16'hE002, 1'b0);
    chk("pre_reset_dv", 33'(m_pack_dv), 33'd1);
    do_reset();
    chk("post_reset_dv", 33'(m_pack_dv), 33'd0);
    m_pack_dr = 1'b1;
    expect_word(1'b0, 32'hE011_E010);
    drive(1'b1, 16'hE010, 1'b0);
    drive(1'b1, 16'hE011, 1'b0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
